logic_unit_pipe: RTL

- Parametrised, pipelined bitwise logic unit for the PipelineMIPS execute path. It generalises the 2-input single-bit AND gate.
- Operates on WIDTH-bit operands and selects one of four ops: AND, OR, XOR, NOR.
- Result passes through STAGES register stages with valid/ready flow control, synchronous flush and a zero flag.
- Feeds the EX/MEM boundary; flush is driven by the hazard unit on branch mispredict.

---
 rtl/logic_unit_pipe.sv | 85 ++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise AND/OR/XOR/NOR unit for the EX path.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = !out_valid || out_ready)
//   op, a, b             op 00 AND, 01 OR, 10 XOR, 11 NOR; WIDTH-bit operands
//   flush                synchronous kill of every in-flight entry
//   out_valid/out_ready  result handshake at the final stage
//   result, zero         registered final-stage result and (result == 0) flag
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0]  w_f;
    logic              w_zero;
    logic              w_adv;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_zero;
    logic [WIDTH-1:0]  r_data [STAGES];

    always_comb begin
        w_f = '0;
        unique case (op)
            2'b00: w_f = a & b;
            2'b01: w_f = a | b;
            2'b10: w_f = a ^ b;
            2'b11: w_f = ~(a | b);
        endcase
    end

    assign w_zero = (w_f == '0);

    // Whole pipe moves as one shift register; bubbles are not collapsed.
    assign w_adv    = !r_valid[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
            r_zero <= '0;
        end else if (w_adv) begin
            r_data[0] <= w_f;
            r_zero[0] <= w_zero;
            for (int i = 1; i < STAGES; i++) begin
                r_data[i] <= r_data[i-1];
                r_zero[i] <= r_zero[i-1];
            end
        end
    end

    // Flush wins over advance and also drops an entry accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign result    = r_data[STAGES-1];
    assign zero      = r_zero[STAGES-1];

endmodule
